// File: rtl/dot_product_scheduler_pkg.sv
// dot_sched_pkg
//   Shared definitions for the dot-product scheduler: default parameter
//   values, requester-id width, FSM state encoding and the round-robin
//   index helper used by the arbiter.
package dot_sched_pkg;

  localparam int DEF_N     = 2;
  localparam int DEF_NBITS = 32;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_LAT   = 6;
  localparam int DEF_DEPTH = 8;

  localparam int ID_W = $clog2(DEF_NREQ);

  typedef logic [1:0] state_t;
  localparam state_t ST_RUN       = 2'd0;
  localparam state_t ST_DRAIN     = 2'd1;
  localparam state_t ST_IDLE_WAIT = 2'd2;

  // Requester index 'off' positions after 'base', wrapped modulo n.
  function automatic int rr_index(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/dot_product_scheduler_if.sv
// dot_product_scheduler_if
//   Bundles the requester, datapath and result-consumer signals of the
//   dot-product scheduler.
//   slave  : scheduler view (drives req_ready, vp_a/vp_b, res_*, idle)
//   master : environment view (drives req_valid/a/b, vp_res, res_ready, flush)
interface dot_product_scheduler_if
  import dot_sched_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int NBITS = DEF_NBITS,
  parameter int NREQ  = DEF_NREQ
) ();

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*N*NBITS-1:0] req_a;
  logic [NREQ*N*NBITS-1:0] req_b;
  logic [NREQ-1:0]         req_ready;
  logic [N*NBITS-1:0]      vp_a;
  logic [N*NBITS-1:0]      vp_b;
  logic [NBITS-1:0]        vp_res;
  logic                    res_valid;
  logic [IDW-1:0]          res_id;
  logic [NBITS-1:0]        res_data;
  logic                    res_ready;
  logic                    flush;
  logic                    idle;

  modport slave (
    input  req_valid, req_a, req_b, vp_res, res_ready, flush,
    output req_ready, vp_a, vp_b, res_valid, res_id, res_data, idle
  );

  modport master (
    output req_valid, req_a, req_b, vp_res, res_ready, flush,
    input  req_ready, vp_a, vp_b, res_valid, res_id, res_data, idle
  );

endinterface

// File: rtl/dot_product_scheduler_rr_arbiter.sv
// rr_arbiter
//   Rotating-priority arbiter. The grant is combinational from req, search
//   starts at ptr; on acceptance of i, ptr moves to (i+1) mod NREQ.
//   clk, rst : clock, async active-high reset (ptr -> 0)
//   req      : request vector
//   en       : grant permitted this cycle
//   gnt      : one-hot grant (only to a requesting input, only when en)
//   gnt_id   : index of the chosen requester
//   accept   : a grant was issued this cycle
module rr_arbiter
  import dot_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            accept
);

  logic [IDW-1:0] ptr;
  logic           found;

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    gnt    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[rr_index(int'(ptr), k, NREQ)]) begin
        found  = 1'b1;
        gnt_id = IDW'(rr_index(int'(ptr), k, NREQ));
      end
    end
    accept = en && found;
    if (accept) gnt[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      if (int'(gnt_id) == NREQ - 1) ptr <= '0;
      else                          ptr <= gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/dot_product_scheduler.sv
// dot_product_scheduler
//   Shares one pipelined dot-product datapath (latency LAT) among NREQ
//   requesters. Round-robin issue of one job per cycle, tag pipe aligning
//   requester ids with vp_res, and a credit-protected result FIFO.
//   clk, rst : clock, async active-high reset
//   bus      : dot_product_scheduler_if.slave (requests, datapath, results,
//              flush, idle)
//   Optional macro DOTSCHED_STATS_EN adds stat_jobs (accepted jobs) and
//   stat_stall (cycles with a request but no grant), both wrapping 32-bit.
//
//   state      | meaning
//   -----------+---------------------------------------------------
//   RUN        | grants allowed while credits remain
//   DRAIN      | flush seen; no grants, wait for tag pipe and FIFO empty
//   IDLE_WAIT  | drained; wait for flush to drop, then back to RUN
module dot_product_scheduler
  import dot_sched_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int NBITS = DEF_NBITS,
  parameter int NREQ  = DEF_NREQ,
  parameter int LAT   = DEF_LAT,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  dot_product_scheduler_if.slave bus
`ifdef DOTSCHED_STATS_EN
  ,
  output logic [31:0]            stat_jobs,
  output logic [31:0]            stat_stall
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int OPW = N * NBITS;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XW  = $clog2(DEPTH + LAT + 2);

  state_t          state, state_nx;
  logic            grant_en;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            accept;

  // Tag pipe: stage 0 sits alongside the vp_a/vp_b register, stage LAT
  // lines up with vp_res.
  logic [LAT:0]    tp_vld;
  logic [IDW-1:0]  tp_id [LAT+1];
  logic [XW-1:0]   inflight;
  logic            credit_ok;

  logic [NBITS-1:0] fd [DEPTH];
  logic [IDW-1:0]   fi [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push, pop;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req_valid),
    .en     (grant_en),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .accept (accept)
  );

  assign bus.req_ready = gnt;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:       if (bus.flush) state_nx = ST_DRAIN;
      ST_DRAIN:     if (inflight == '0 && cnt == '0) state_nx = ST_IDLE_WAIT;
      ST_IDLE_WAIT: if (!bus.flush) state_nx = ST_RUN;
      default:      state_nx = ST_RUN;
    endcase
  end

  // FSM: outputs. Gating with rst keeps req_ready low during reset even
  // when requesters hold valid.
  always_comb begin
    grant_en = !rst && (state == ST_RUN) && credit_ok;
    bus.idle = ((state != ST_RUN) || !(|bus.req_valid)) &&
               (inflight == '0) && (cnt == '0);
  end

  // Credits count against both queued and in-flight results; a pop only
  // frees a credit once cnt has updated.
  always_comb begin
    inflight = '0;
    for (int k = 0; k <= LAT; k++) inflight = inflight + XW'(tp_vld[k]);
    credit_ok = (inflight + XW'(cnt)) < XW'(DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.vp_a <= '0;
      bus.vp_b <= '0;
    end else if (accept) begin
      bus.vp_a <= bus.req_a[int'(gnt_id)*OPW +: OPW];
      bus.vp_b <= bus.req_b[int'(gnt_id)*OPW +: OPW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_vld <= '0;
      for (int k = 0; k <= LAT; k++) tp_id[k] <= '0;
    end else begin
      tp_vld   <= {tp_vld[LAT-1:0], accept};
      tp_id[0] <= gnt_id;
      for (int k = 1; k <= LAT; k++) tp_id[k] <= tp_id[k-1];
    end
  end

  assign push = tp_vld[LAT];
  assign pop  = (cnt != '0) && bus.res_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fd[wr_ptr] <= bus.vp_res;
      fi[wr_ptr] <= tp_id[LAT];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign bus.res_valid = (cnt != '0);
  assign bus.res_id    = bus.res_valid ? fi[rd_ptr] : '0;
  assign bus.res_data  = bus.res_valid ? fd[rd_ptr] : '0;

  a_no_push_at_full: assert property (@(posedge clk) disable iff (rst)
    !(push && cnt == CW'(DEPTH)));

`ifdef DOTSCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_jobs  <= '0;
      stat_stall <= '0;
    end else begin
      if (accept) stat_jobs <= stat_jobs + 32'd1;
      if (|bus.req_valid && !accept) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
